// File: rtl/merger_pkg.sv
// Shared width helpers for the merger leaf feeder.
// Widths depend on module parameters, so they are exposed as constant functions.
package merger_pkg;

  function automatic int entry_w(input int data_width);
    return 4 * data_width;
  endfunction

  function automatic int leaf_w(input int l);
    return $clog2(2 * l);
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/merger_leaf_feeder_if.sv
// Tagged input word stream feeding the leaf FIFOs.
// Holds the valid/ready handshake plus the destination leaf tag.
interface merger_leaf_feeder_if
  import merger_pkg::*;
#(
  parameter int L          = 2,
  parameter int DATA_WIDTH = 32
);
  localparam int EW = entry_w(DATA_WIDTH);
  localparam int LW = leaf_w(L);

  logic [EW-1:0] in_data;
  logic [LW-1:0] in_leaf;
  logic          in_valid;
  logic          in_ready;

  modport master (
    output in_data,
    output in_leaf,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_leaf,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/merger_leaf_fifo.sv
// Single first-word-fall-through circular buffer for one merger leaf.
// Pointers carry one extra wrap bit to tell full from empty.
module merger_leaf_fifo
  import merger_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int EW         = entry_w(DATA_WIDTH),
  localparam int PW         = ptr_w(DEPTH),
  localparam int AW         = PW - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [EW-1:0] wdata,
  output logic [EW-1:0] rdata,
  output logic          empty,
  output logic          full,
  output logic [PW-1:0] level,
  output logic          pop_err
);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
                 & (wr_ptr[AW] != rd_ptr[AW]);
  assign level   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign pop_ok  = pop & ~empty;
  assign pop_err = pop & empty;
  // a full leaf may still take a write when its head leaves this cycle
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/merger_leaf_feeder.sv
// Steers tagged input words into 2*L leaf FIFOs for the merger tree.
// Exposes packed head words, empties and levels; tracks sticky underflow.
module merger_leaf_feeder
  import merger_pkg::*;
#(
  parameter  int L          = 2,
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int NL         = 2 * L,
  localparam int EW         = entry_w(DATA_WIDTH),
  localparam int LW         = leaf_w(L),
  localparam int PW         = ptr_w(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  merger_leaf_feeder_if.slave in_if,
  output logic [EW*NL-1:0]   o_fifo,
  output logic [NL-1:0]      o_fifo_empty,
  input  logic [NL-1:0]      i_fifo_read,
  output logic [NL*PW-1:0]   o_level,
  output logic               o_underflow
);

  logic [NL-1:0] full;
  logic [NL-1:0] push;
  logic [NL-1:0] pop_err;
  logic          ready;

  // out-of-range tags match no leaf and so are never ready
  always_comb begin
    ready = 1'b0;
    push  = '0;
    for (int k = 0; k < NL; k++) begin
      if (in_if.in_leaf == LW'(k)) begin
        ready = ~full[k] | i_fifo_read[k];
      end
    end
    for (int k = 0; k < NL; k++) begin
      push[k] = in_if.in_valid & ready
              & (in_if.in_leaf == LW'(k));
    end
  end

  assign in_if.in_ready = ready;

  for (genvar k = 0; k < NL; k++) begin : g_leaf
    merger_leaf_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .push    (push[k]),
      .pop     (i_fifo_read[k]),
      .wdata   (in_if.in_data),
      .rdata   (o_fifo[k*EW +: EW]),
      .empty   (o_fifo_empty[k]),
      .full    (full[k]),
      .level   (o_level[k*PW +: PW]),
      .pop_err (pop_err[k])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_underflow <= 1'b0;
    else if (|pop_err) o_underflow <= 1'b1;
  end

endmodule

// File: tb/tb_merger_leaf_feeder.sv
// Self-checking bench for merger_leaf_feeder (L=2, 32-bit records, depth 4).
// Table vectors, hand sequences, random traffic and a merge-style drain.
module tb_merger_leaf_feeder;

  localparam int NL = 4;
  localparam int EW = 128;
  localparam int PW = 3;
  localparam int DP = 4;

  logic              clk;
  logic              rst_n;
  logic [EW*NL-1:0]  fifo;
  logic [NL-1:0]     fifo_empty;
  logic [NL-1:0]     fifo_read;
  logic [NL*PW-1:0]  level;
  logic              underflow;

  merger_leaf_feeder_if #(.L(2), .DATA_WIDTH(32)) bus ();

  merger_leaf_feeder #(.L(2), .DATA_WIDTH(32), .DEPTH(DP)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .in_if        (bus),
    .o_fifo       (fifo),
    .o_fifo_empty (fifo_empty),
    .i_fifo_read  (fifo_read),
    .o_level      (level),
    .o_underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  logic [EW-1:0] mq [NL][$];
  bit            muf;

  typedef struct {
    logic          v;
    logic [1:0]    leaf;
    logic [EW-1:0] d;
    logic [3:0]    rd;
    logic          exp_ready;
    logic [3:0]    exp_empty;
    logic          exp_uf;
  } vec_t;

  task automatic chk(input string name, input logic [EW-1:0] act,
                     input logic [EW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] head(input int k);
    return fifo[k*EW +: EW];
  endfunction

  function automatic logic [PW-1:0] lvl(input int k);
    return level[k*PW +: PW];
  endfunction

  task automatic apply(input logic v, input logic [1:0] leaf,
                       input logic [EW-1:0] d, input logic [3:0] rd);
    bus.in_valid = v;
    bus.in_leaf  = leaf;
    bus.in_data  = d;
    fifo_read    = rd;
    #1;
  endtask

  task automatic model_check();
    bit er;
    er = (mq[bus.in_leaf].size() < DP) || fifo_read[bus.in_leaf];
    chk("ready", {127'd0, bus.in_ready}, {127'd0, er});
    chk("uflow", {127'd0, underflow}, {127'd0, muf});
    for (int k = 0; k < NL; k++) begin
      chk($sformatf("empty%0d", k), {127'd0, fifo_empty[k]},
          {127'd0, mq[k].size() == 0});
      chk($sformatf("level%0d", k), {125'd0, lvl(k)},
          EW'(mq[k].size()));
      if (mq[k].size() != 0)
        chk($sformatf("head%0d", k), head(k), mq[k][0]);
    end
  endtask

  task automatic advance();
    bit acc;
    acc = bus.in_valid &&
          ((mq[bus.in_leaf].size() < DP) || fifo_read[bus.in_leaf]);
    for (int k = 0; k < NL; k++) begin
      if (fifo_read[k]) begin
        if (mq[k].size() == 0) muf = 1'b1;
        else void'(mq[k].pop_front());
      end
    end
    if (acc) mq[bus.in_leaf].push_back(bus.in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic v, input logic [1:0] leaf,
                       input logic [EW-1:0] d, input logic [3:0] rd);
    apply(v, leaf, d, rd);
    model_check();
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_empty", {124'd0, fifo_empty}, 128'hF);
    chk("rst_level", {116'd0, level}, 128'h0);
    chk("rst_uflow", {127'd0, underflow}, 128'h0);
    chk("rst_fifo0", head(0), 128'h0);
    chk("rst_fifo3", head(3), 128'h0);
    for (int k = 0; k < NL; k++) mq[k].delete();
    muf = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl[9];
  logic [EW-1:0] rw;
  logic [3:0]    rd;
  int            nxt;
  int            best;

  initial begin
    vectors     = 0;
    miscompares = 0;
    muf         = 1'b0;
    rst_n       = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_leaf  = '0;
    bus.in_data  = '0;
    fifo_read    = '0;
    #2;
    do_reset();
    for (int k = 0; k < NL; k++) begin
      apply(1'b0, 2'(k), '0, 4'b0);
      chk("rst_ready", {127'd0, bus.in_ready}, 128'h1);
    end

    tbl[0] = '{1'b0, 2'd0, 128'h0,  4'b0000, 1'b1, 4'b1111, 1'b0};
    tbl[1] = '{1'b1, 2'd2, 128'h11, 4'b0000, 1'b1, 4'b1111, 1'b0};
    tbl[2] = '{1'b0, 2'd2, 128'h0,  4'b0000, 1'b1, 4'b1011, 1'b0};
    tbl[3] = '{1'b0, 2'd2, 128'h0,  4'b0100, 1'b1, 4'b1011, 1'b0};
    tbl[4] = '{1'b0, 2'd0, 128'h0,  4'b0000, 1'b1, 4'b1111, 1'b0};
    tbl[5] = '{1'b0, 2'd0, 128'h0,  4'b0001, 1'b1, 4'b1111, 1'b0};
    tbl[6] = '{1'b0, 2'd0, 128'h0,  4'b0000, 1'b1, 4'b1111, 1'b1};
    tbl[7] = '{1'b1, 2'd0, 128'h22, 4'b0001, 1'b1, 4'b1111, 1'b1};
    tbl[8] = '{1'b0, 2'd0, 128'h0,  4'b0000, 1'b1, 4'b1110, 1'b1};
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].v, tbl[i].leaf, tbl[i].d, tbl[i].rd);
      chk($sformatf("t%0d_ready", i), {127'd0, bus.in_ready},
          {127'd0, tbl[i].exp_ready});
      chk($sformatf("t%0d_empty", i), {124'd0, fifo_empty},
          {124'd0, tbl[i].exp_empty});
      chk($sformatf("t%0d_uflow", i), {127'd0, underflow},
          {127'd0, tbl[i].exp_uf});
      model_check();
      advance();
    end
    apply(1'b0, 2'd0, '0, 4'b0);
    chk("uf_head0", head(0), 128'h22);
    do_reset();

    // fill and wrap on leaf 1
    cycle(1'b1, 2'd1, 128'hA, 4'b0);
    cycle(1'b1, 2'd1, 128'hB, 4'b0);
    cycle(1'b1, 2'd1, 128'hC, 4'b0);
    cycle(1'b1, 2'd1, 128'hD, 4'b0);
    apply(1'b0, 2'd1, '0, 4'b0);
    chk("wrap_lvl1", {125'd0, lvl(1)}, 128'h4);
    chk("wrap_rdy1", {127'd0, bus.in_ready}, 128'h0);
    apply(1'b0, 2'd0, '0, 4'b0);
    chk("wrap_rdy0", {127'd0, bus.in_ready}, 128'h1);
    apply(1'b0, 2'd1, '0, 4'b0010);
    chk("wrap_popA", head(1), 128'hA);
    advance();
    apply(1'b0, 2'd1, '0, 4'b0010);
    chk("wrap_popB", head(1), 128'hB);
    advance();
    cycle(1'b1, 2'd1, 128'hE, 4'b0);
    cycle(1'b1, 2'd1, 128'hF, 4'b0);
    rw = 128'hC;
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 2'd1, '0, 4'b0010);
      chk("wrap_seq", head(1), rw);
      model_check();
      advance();
      rw = rw + 1;
    end

    // full pass-through on leaf 3
    for (int i = 1; i <= 4; i++) cycle(1'b1, 2'd3, EW'(32'h60 + i), 4'b0);
    apply(1'b1, 2'd3, 128'h6F, 4'b1000);
    chk("pass_rdy", {127'd0, bus.in_ready}, 128'h1);
    model_check();
    advance();
    apply(1'b0, 2'd3, '0, 4'b0);
    chk("pass_lvl", {125'd0, lvl(3)}, 128'h4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 2'd3, '0, 4'b1000);
    chk("pass_uf", {127'd0, underflow}, 128'h0);

    // random traffic with a reset in the middle
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      rd = '0;
      for (int k = 0; k < NL; k++)
        if ($urandom_range(0, 2) == 0 &&
            (mq[k].size() != 0 || $urandom_range(0, 19) == 0))
          rd[k] = 1'b1;
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            {$urandom, $urandom, $urandom, $urandom}, rd);
    end

    // merge-style drain: four sorted runs must come out 1..32
    do_reset();
    for (int k = 0; k < NL; k++)
      for (int w = 0; w < 2; w++)
        cycle(1'b1, 2'(k),
              {32'(8*k + 4*w + 4), 32'(8*k + 4*w + 3),
               32'(8*k + 4*w + 2), 32'(8*k + 4*w + 1)}, 4'b0);
    nxt = 1;
    for (int c = 0; c < 60 && nxt <= 32; c++) begin
      apply(1'b0, 2'd0, '0, 4'b0);
      best = -1;
      for (int k = 0; k < NL; k++)
        if (!fifo_empty[k] &&
            (best < 0 || head(k)[31:0] < head(best)[31:0])) best = k;
      if (best < 0) break;
      for (int r = 0; r < 4; r++) begin
        chk("merge_rec", {96'd0, head(best)[32*r +: 32]}, EW'(nxt));
        nxt++;
      end
      cycle(1'b0, 2'd0, '0, 4'(1 << best));
    end
    chk("merge_count", EW'(nxt), 128'd33);
    chk("merge_uf", {127'd0, underflow}, 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
